// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
//   Buffers a host-loaded vector of 4-bit operand pairs and streams it into a
//   free-running 4x4 MAC, one pair per clock. The MAC has no clear, so the
//   accumulator is snapshotted when a run starts. When the run ends, the
//   modulo-256 difference is reported as the dot product for that vector.
//
// Ports
//   clk       rising-edge clock shared with the MAC
//   rst_n     synchronous active-low reset
//   in_valid  host offers an operand pair
//   in_ready  buffer accepts a pair this cycle
//   in_data   operand pair {b[7:4], a[3:0]}
//   start     begin streaming the buffered vector (ignored while busy)
//   mac_a     registered operand a to the MAC (0 when not streaming)
//   mac_b     registered operand b to the MAC (0 when not streaming)
//   mac_acc   MAC accumulator output (acc <= acc + a*b every edge)
//   result    dot product of the last vector, modulo 256
//   done      one-cycle pulse when result is updated
//   busy      high in FEED and SETTLE
//   count     number of pairs currently buffered
module mac_operand_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   start,
    output logic [3:0]             mac_a,
    output logic [3:0]             mac_b,
    input  logic [7:0]             mac_acc,
    output logic [7:0]             result,
    output logic                   done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        SETTLE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          wr_en;
    logic          rd_en;
    logic          empty_done;
    logic          settle_done;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    base;
    logic [7:0]    mem [DEPTH];

    assign busy     = (state != IDLE);
    assign in_ready = (state == IDLE) && (count < FULL) && !start;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a value held (no latch).
    always_comb begin
        next_state  = state;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        empty_done  = 1'b0;
        settle_done = 1'b0;
        case (state)
            IDLE: begin
                // in_ready already excludes start, so a write and a run
                // start never share an edge.
                wr_en = in_valid && in_ready;
                if (start) begin
                    if (count != '0) begin
                        rd_en      = 1'b1;
                        next_state = FEED;
                    end else begin
                        empty_done = 1'b1;
                    end
                end
            end
            FEED: begin
                if (count != '0) begin
                    rd_en = 1'b1;
                end else begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                // Operands are zero for this cycle, so mac_acc is final.
                settle_done = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the operand buffer has no reset; only pointers and count define
    // which entries are live, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others, matching hardware behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mac_a  <= '0;
            mac_b  <= '0;
            result <= '0;
            done   <= 1'b0;
            base   <= '0;
        end else begin
            state <= next_state;
            done  <= empty_done || settle_done;

            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + (AW + 1)'(1);
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
                count  <= count - (AW + 1)'(1);
            end

            // Outside a read, operands drop to zero so the MAC holds its value.
            if (rd_en) begin
                {mac_b, mac_a} <= mem[rd_ptr];
            end else begin
                {mac_b, mac_a} <= '0;
            end

            // Operands are still zero at the start edge, so the accumulator
            // sampled here equals its value after that edge.
            if (state == IDLE && rd_en) begin
                base <= mac_acc;
            end

            if (empty_done) begin
                result <= '0;
            end else if (settle_done) begin
                result <= mac_acc - base;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Testbench for mac_operand_feeder. A behavioural MAC drives mac_acc. The
// driver keeps a reference model: a queue of buffered pairs and the cycle at
// which the current run ends. Each accepted start pushes the expected operand
// stream and the expected {result, done cycle}. A monitor pops and compares
// whenever the DUT is busy or pulses done.
module tb_mac_operand_feeder;

    localparam int DEPTH = 8;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
    } op_t;

    typedef struct {
        logic [7:0] res;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       start;
    logic [3:0] mac_a;
    logic [3:0] mac_b;
    logic [7:0] mac_acc;
    logic [7:0] result;
    logic       done;
    logic       busy;
    logic [3:0] count;

    logic [7:0] acc;
    logic [7:0] acc_preset;
    logic       acc_load;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         busy_until = -1;
    bit         model_valid = 0;
    bit         mon_en = 0;
    int         done_count = 0;

    logic [7:0] fifo_m[$];
    op_t        exp_ops[$];
    exp_t       exp_res[$];

    mac_operand_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .start    (start),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_acc  (mac_acc),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4x4 MAC with a bench-only preset.
    assign mac_acc = acc;
    always @(posedge clk) begin
        if (acc_load) acc <= acc_preset;
        else          acc <= acc + ({4'b0, mac_a} * {4'b0, mac_b});
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock of stimulus. Inputs are applied just after an edge, in_ready
    // is checked at the falling edge, and the model steps just after the next
    // rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic s);
        int c;
        int sum;
        int n;
        in_valid = v;
        in_data  = d;
        start    = s;
        @(negedge clk);
        if (model_valid)
            check("in_ready", 32'(in_ready),
                  32'((cyc + 1 > busy_until) && !s && fifo_m.size() < DEPTH));
        @(posedge clk);
        #1;
        c = cyc;
        if (!rst_n) begin
            fifo_m.delete();
            exp_ops.delete();
            exp_res.delete();
            busy_until  = c;
            model_valid = 1;
        end else if (model_valid) begin
            if (s && c > busy_until) begin
                if (fifo_m.size() == 0) begin
                    exp_res.push_back('{8'h00, c});
                    busy_until = c;
                end else begin
                    sum = 0;
                    n   = fifo_m.size();
                    foreach (fifo_m[i]) begin
                        sum += int'(fifo_m[i][3:0]) * int'(fifo_m[i][7:4]);
                        exp_ops.push_back('{fifo_m[i][3:0], fifo_m[i][7:4]});
                    end
                    exp_ops.push_back('{4'h0, 4'h0});
                    exp_res.push_back('{8'(sum), c + n + 1});
                    busy_until = c + n + 1;
                    fifo_m.delete();
                end
            end else if (v && c > busy_until && fifo_m.size() < DEPTH) begin
                fifo_m.push_back(d);
            end
            check("busy", 32'(busy), 32'(c < busy_until));
            if (c >= busy_until) check("count", 32'(count), 32'(fifo_m.size()));
        end
    endtask

    task automatic set_acc(input logic [7:0] v);
        acc_preset = v;
        acc_load   = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        acc_load   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_res.size() != 0 || exp_ops.size() != 0) && n < 60) begin
            cycle(1'b0, 8'h00, 1'b0);
            n++;
        end
        check("drain_pending", 32'(exp_res.size() + exp_ops.size()), 32'd0);
    endtask

    // Monitor: compares the operand stream while busy and every done pulse.
    always @(negedge clk) begin
        op_t  op;
        exp_t e;
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (exp_ops.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL operands: busy at cycle %0d with no expected operand", cyc);
                end else begin
                    op = exp_ops.pop_front();
                    check("mac_a", 32'(mac_a), 32'(op.a));
                    check("mac_b", 32'(mac_b), 32'(op.b));
                end
            end else begin
                check("mac_a_idle", 32'(mac_a), 32'd0);
                check("mac_b_idle", 32'(mac_b), 32'd0);
            end
            if (done === 1'b1) begin
                done_count++;
                if (exp_res.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done: unexpected pulse at cycle %0d, result %0h", cyc, result);
                end else begin
                    e = exp_res.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("done_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        start      = 1'b1;
        in_data    = 8'hFF;
        acc_preset = 8'h00;
        acc_load   = 1'b1;

        // Reset held two cycles with in_valid and start asserted.
        cycle(1'b1, 8'hFF, 1'b1);
        mon_en   = 1;
        acc_load = 1'b0;
        cycle(1'b1, 8'hFF, 1'b1);
        check("rst_mac_a", 32'(mac_a), 32'd0);
        check("rst_mac_b", 32'(mac_b), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic vector: 0x10 + 6 + 25 + 15.
        set_acc(8'h10);
        cycle(1'b1, 8'h23, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b1, 8'h1F, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        drain();
        check("basic_result", 32'(result), 32'h2E);
        check("basic_acc", 32'(acc), 32'h3E);

        // Full buffer: nine offers, eight accepted.
        repeat (9) cycle(1'b1, 8'hFF, 1'b0);
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b0, 8'h00, 1'b1);
        drain();
        check("full_result", 32'(result), 32'h08);

        // Empty start, then a vector whose result wraps the accumulator.
        cycle(1'b0, 8'h00, 1'b1);
        drain();
        check("empty_result", 32'(result), 32'h00);
        set_acc(8'hF0);
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        drain();
        check("wrap_result", 32'(result), 32'h19);
        check("wrap_acc", 32'(acc), 32'h09);

        // Abort: reset lands on the edge after the second operand appears.
        repeat (4) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        check("abort_mac_a", 32'(mac_a), 32'd0);
        check("abort_mac_b", 32'(mac_b), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        dc    = done_count;
        repeat (12) cycle(1'b0, 8'h00, 1'b0);
        check("abort_no_done", 32'(done_count), 32'(dc));

        // Busy gating: start and in_valid pulsed throughout a 5-pair run.
        set_acc(8'($urandom));
        repeat (5) cycle(1'b1, 8'($urandom), 1'b0);
        dc = done_count;
        cycle(1'b0, 8'h00, 1'b1);
        repeat (6) cycle(1'b1, 8'($urandom), 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        drain();
        check("gate_done_count", 32'(done_count), 32'(dc + 1));
        check("gate_count", 32'(count), 32'd0);

        // Randomised traffic against the model.
        repeat (500) cycle(($urandom % 3) != 0, 8'($urandom), ($urandom % 10) == 0);
        cycle(1'b0, 8'h00, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
